// File: rtl/ras_pkg.sv
// Shared parameters and checkpoint type for the return-address stack.
package ras_pkg;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  localparam logic [RAS_PTR_W:0] RAS_FULL = RAS_PTR_W'(RAS_DEPTH) | (RAS_PTR_W+1)'(RAS_DEPTH);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_PTR_W:0]   count;
    logic [XLEN-1:0]      top;
  } ras_ckpt_t;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack for the 2-wide fetch stage, with checkpoint export.
// RAS_CKPT_RESTORE_EN: restore pointer/count/top from a checkpoint on mispredict; otherwise flush.
module return_address_stack
  import ras_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  input  logic            fetch_fire,
  input  logic [XLEN-1:0] pc,
  input  logic            is_call1,
  input  logic            is_call2,
  input  logic            is_ret1,
  input  logic            is_ret2,
  input  logic            mispredict,
  input  ras_ckpt_t       restore_ckpt,
  output logic [XLEN-1:0] ret_addr1,
  output logic [XLEN-1:0] ret_addr2,
  output logic            ret_valid1,
  output logic            ret_valid2,
  output ras_ckpt_t       ckpt
);

  logic [XLEN-1:0]      stack [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] tos, tos_n, wr_idx;
  logic [RAS_PTR_W:0]   count, count_n;
  logic [XLEN-1:0]      top, wr_data, link;
  logic                 wr_en, s_call, s_ret, nonempty;

  assign nonempty   = (count != '0);
  assign top        = nonempty ? stack[tos] : '0;
  assign ret_addr1  = top;
  assign ret_addr2  = top;
  assign ret_valid1 = nonempty;
  assign ret_valid2 = nonempty;
  assign ckpt       = '{tos: tos, count: count, top: top};

`ifndef RAS_CKPT_RESTORE_EN
  logic unused_restore;
  assign unused_restore = ^restore_ckpt;
`endif

  always_comb begin
    tos_n   = tos;
    count_n = count;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = '0;
    s_call  = 1'b0;
    s_ret   = 1'b0;
    link    = '0;
    if (mispredict) begin
`ifdef RAS_CKPT_RESTORE_EN
      tos_n   = restore_ckpt.tos;
      count_n = restore_ckpt.count;
      wr_en   = (restore_ckpt.count != '0);
      wr_idx  = restore_ckpt.tos;
      wr_data = restore_ckpt.top;
`else
      tos_n   = '0;
      count_n = '0;
`endif
    end else if (fetch_fire) begin
      // A slot-1 call/ret redirects fetch, so only one slot ever acts per cycle.
      if (is_call1 || is_ret1) begin
        s_call = is_call1;
        s_ret  = is_ret1;
        link   = pc + 32'd4;
      end else begin
        s_call = is_call2;
        s_ret  = is_ret2;
        link   = pc + 32'd8;
      end
      if (s_call && s_ret && nonempty) begin
        wr_en   = 1'b1;
        wr_data = link;
      end else if (s_call) begin
        tos_n   = tos + 1'b1;
        wr_en   = 1'b1;
        wr_idx  = tos + 1'b1;
        wr_data = link;
        if (count != RAS_FULL) count_n = count + 1'b1;
      end else if (s_ret && nonempty) begin
        tos_n   = tos - 1'b1;
        count_n = count - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tos   <= '0;
      count <= '0;
    end else begin
      tos   <= tos_n;
      count <= count_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && wr_en) stack[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed scenarios plus a random run vs a queue model.
module tb_return_address_stack;
  import ras_pkg::*;

  logic            CLK = 1'b0;
  logic            reset, fetch_fire, mispredict;
  logic [XLEN-1:0] pc;
  logic            is_call1, is_call2, is_ret1, is_ret2;
  ras_ckpt_t       restore_ckpt;
  logic [XLEN-1:0] ret_addr1, ret_addr2;
  logic            ret_valid1, ret_valid2;
  ras_ckpt_t       ckpt;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  int          m_tos;

  return_address_stack dut (
    .CLK(CLK), .reset(reset), .fetch_fire(fetch_fire), .pc(pc),
    .is_call1(is_call1), .is_call2(is_call2), .is_ret1(is_ret1), .is_ret2(is_ret2),
    .mispredict(mispredict), .restore_ckpt(restore_ckpt),
    .ret_addr1(ret_addr1), .ret_addr2(ret_addr2),
    .ret_valid1(ret_valid1), .ret_valid2(ret_valid2), .ckpt(ckpt)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    fetch_fire = 0; mispredict = 0; reset = 0;
    is_call1 = 0; is_call2 = 0; is_ret1 = 0; is_ret2 = 0;
    pc = '0; restore_ckpt = '0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    idle();
  endtask

  task automatic fire(input logic [31:0] p, input logic c1, input logic r1,
                      input logic c2, input logic r2);
    fetch_fire = 1; pc = p; is_call1 = c1; is_ret1 = r1; is_call2 = c2; is_ret2 = r2;
    tick();
  endtask

  // Abstract model: a bounded stack of link addresses; oldest falls off when over-full.
  task automatic model_slot(input logic c, input logic r, input logic [31:0] link);
    if (c && r && q.size() != 0) q[q.size()-1] = link;
    else if (c) begin
      q.push_back(link);
      if (q.size() > RAS_DEPTH) void'(q.pop_front());
      m_tos = (m_tos + 1) % RAS_DEPTH;
    end else if (r && q.size() != 0) begin
      void'(q.pop_back());
      m_tos = (m_tos + RAS_DEPTH - 1) % RAS_DEPTH;
    end
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    @(posedge CLK); @(posedge CLK); #1;
    idle();
    total++; if (ret_valid1 !== 1'b0 || ret_valid2 !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%b%b exp=00", ret_valid1, ret_valid2); end
    total++; if (ret_addr1 !== 32'h0 || ret_addr2 !== 32'h0) begin bad++;
      $display("FAIL reset_addr got=%h/%h exp=0", ret_addr1, ret_addr2); end
    total++; if (ckpt !== ras_ckpt_t'('0)) begin bad++;
      $display("FAIL reset_ckpt got=%h exp=0", ckpt); end
  endtask

  task automatic test_call_ret();
    fire(32'h100, 1, 0, 0, 0);
    total++; if (ret_addr1 !== 32'h104 || ret_valid1 !== 1'b1 || ret_addr2 !== 32'h104) begin bad++;
      $display("FAIL call1 got=%h v=%b exp=104 v=1", ret_addr1, ret_valid1); end
    fire(32'h180, 0, 1, 0, 0);
    total++; if (ckpt.count !== 5'd0 || ret_valid1 !== 1'b0 || ret_valid2 !== 1'b0) begin bad++;
      $display("FAIL ret1 got count=%0d v=%b exp count=0 v=0", ckpt.count, ret_valid1); end
  endtask

  task automatic test_slot2();
    fire(32'h200, 0, 0, 1, 0);
    total++; if (ret_addr1 !== 32'h208 || ckpt.count !== 5'd1) begin bad++;
      $display("FAIL call2 got=%h count=%0d exp=208 count=1", ret_addr1, ckpt.count); end
    fire(32'h300, 1, 0, 1, 0);
    total++; if (ret_addr1 !== 32'h304 || ckpt.count !== 5'd2) begin bad++;
      $display("FAIL squash got=%h count=%0d exp=304 count=2", ret_addr1, ckpt.count); end
    fire(32'h380, 0, 1, 0, 1);
    fire(32'h390, 0, 1, 0, 0);
  endtask

  task automatic test_overflow();
    int errs = 0;
    for (int i = 0; i <= 16; i++) fire(32'h1000 + 16*i, 1, 0, 0, 0);
    total++; if (ckpt.count !== 5'd16 || ret_addr1 !== 32'h1104) begin bad++;
      $display("FAIL full got count=%0d top=%h exp count=16 top=1104", ckpt.count, ret_addr1); end
    for (int k = 0; k < 16; k++) begin
      if (ret_addr1 !== 32'h1104 - 16*k || ret_valid1 !== 1'b1) begin
        errs++; $display("FAIL pop_%0d got=%h exp=%h", k, ret_addr1, 32'h1104 - 16*k);
      end
      fire(32'h2000, 0, 1, 0, 0);
    end
    total++; if (errs != 0) bad++;
    total++; if (ret_valid1 !== 1'b0 || ckpt.count !== 5'd0) begin bad++;
      $display("FAIL drained got v=%b count=%0d exp v=0 count=0", ret_valid1, ckpt.count); end
    fire(32'h2000, 0, 1, 0, 0);
    total++; if (ret_valid1 !== 1'b0 || ckpt.count !== 5'd0) begin bad++;
      $display("FAIL underflow got v=%b count=%0d exp v=0 count=0", ret_valid1, ckpt.count); end
  endtask

  task automatic test_mispredict();
    ras_ckpt_t saved;
    fire(32'h100, 1, 0, 0, 0);
    saved = ckpt;
    fire(32'h140, 0, 1, 0, 0);
    fire(32'h500, 1, 0, 0, 0);
    total++; if (ret_addr1 !== 32'h504) begin bad++;
      $display("FAIL wrong_path got=%h exp=504", ret_addr1); end
    mispredict = 1; restore_ckpt = saved; tick();
`ifdef RAS_CKPT_RESTORE_EN
    total++; if (ret_addr1 !== 32'h104 || ckpt.count !== 5'd1) begin bad++;
      $display("FAIL restore got=%h count=%0d exp=104 count=1", ret_addr1, ckpt.count); end
`else
    total++; if (ckpt.count !== 5'd0 || ret_valid1 !== 1'b0) begin bad++;
      $display("FAIL flush got count=%0d exp=0", ckpt.count); end
`endif
    saved = ckpt;
    mispredict = 1; restore_ckpt = saved;
    fetch_fire = 1; pc = 32'h700; is_call1 = 1; tick();
    total++; if (ret_addr1 === 32'h704 || ckpt.count !== saved.count) begin bad++;
      $display("FAIL mp_vs_fire got=%h count=%0d exp count=%0d", ret_addr1, ckpt.count, saved.count); end
    fire(32'h800, 1, 0, 0, 0);
    reset = 1; mispredict = 1; restore_ckpt = '{tos: 4'd3, count: 5'd1, top: 32'hABC}; tick();
    total++; if (ckpt.count !== 5'd0 || ret_valid1 !== 1'b0) begin bad++;
      $display("FAIL reset_vs_mp got count=%0d exp=0", ckpt.count); end
  endtask

  task automatic test_random();
    logic c1, r1, c2, r2, f;
    logic [31:0] p;
    int errs = 0;
    idle(); reset = 1; tick();
    q.delete(); m_tos = 0;
    for (int n = 0; n < 400; n++) begin
      f  = ($urandom_range(3) != 0);
      c1 = ($urandom_range(3) == 0); r1 = ($urandom_range(3) == 0);
      c2 = ($urandom_range(2) == 0); r2 = ($urandom_range(2) == 0);
      p  = $urandom & 32'hFFFF_FFFC;
      if (f) begin
        if (c1 || r1) model_slot(c1, r1, p + 32'd4);
        else          model_slot(c2, r2, p + 32'd8);
      end
      fetch_fire = f; pc = p; is_call1 = c1; is_ret1 = r1; is_call2 = c2; is_ret2 = r2;
      tick();
      if (ckpt.count !== 5'(q.size()) || ret_valid1 !== (q.size() != 0) ||
          ret_valid2 !== (q.size() != 0) || ckpt.tos !== 4'(m_tos) ||
          ret_addr1 !== (q.size() != 0 ? q[q.size()-1] : 32'h0) ||
          ret_addr2 !== ret_addr1 || ckpt.top !== ret_addr1) begin
        errs++;
        if (errs < 6) $display("FAIL random_%0d got count=%0d tos=%0d top=%h exp count=%0d tos=%0d top=%h",
          n, ckpt.count, ckpt.tos, ret_addr1, q.size(), m_tos, (q.size() != 0 ? q[q.size()-1] : 32'h0));
      end
    end
    total++; if (errs != 0) bad++;
  endtask

  initial begin
    idle();
    test_reset();
    test_call_ret();
    test_slot2();
    test_overflow();
    test_mispredict();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
